ccff_prog_ctrl: RTL and testbench
=================================

# ccff_prog_ctrl

Configuration-chain programming controller for the FPGA fabric. Accepts bitstream words from an upstream loader over a valid/ready handshake. Serializes them MSB-first onto `ccff_head` and gates chain shifting through `ccff_shift_en`. Also provides a chain-integrity self-test: it launches a single pulse and checks that the pulse emerges on `ccff_tail` after exactly `BITSTREAM_SIZE` shifts. Sits between the bitstream loader and the fabric's `ccff_head`/`ccff_tail`/`prog_clk` pins.

## Interface
- `WORD_WIDTH`, default 32, width of a bitstream word.
- `BITSTREAM_SIZE`, default 65656, configuration-chain length in bits.
- `CNT_WIDTH`, default 24, width of bit/cycle counters; must satisfy 2^CNT_WIDTH > BITSTREAM_SIZE + CHECK_MARGIN.
- `CHECK_MARGIN`, default 4, extra cycles past `BITSTREAM_SIZE` before the self-test times out.

Ports:
- `prog_clk`  in  1  programming clock; single clock domain.
- `prog_reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `mode`  in  1  sampled with `start`: 0 = program, 1 = chain self-test.
- `word_data`  in  WORD_WIDTH  bitstream word.
- `word_valid`  in  1  `word_data` valid.
- `word_ready`  out  1  holding register empty; a transfer occurs when `word_valid & word_ready`.
- `ccff_head`  out  1  registered serial bit to chain head.
- `ccff_tail`  in  1  chain tail.
- `ccff_shift_en`  out  1  registered; chain shifts at the `prog_clk` edge ending any cycle in which it is 1.
- `busy`  out  1  high in any state other than IDLE.
- `config_done`  out  1  sticky; set on successful completion; cleared by next accepted `start`.
- `error`  out  1  sticky self-test failure; cleared by next accepted `start`.
- `bit_count`  out  CNT_WIDTH  bits shifted (program) or cycles elapsed (self-test).

## Operation
- Reset values: `ccff_head`=0, `ccff_shift_en`=0, `word_ready`=0, `busy`=0, `config_done`=0, `error`=0, `bit_count`=0, state IDLE, both word registers empty.
- Storage is double-buffered: a holding register (fed by the handshake) and a shift register (feeds `ccff_head`). `word_ready`=1 only in PROG with the holding register empty.
- States:
  - **IDLE**
    - `start`&`mode`=0 → PROG.
    - `start`&`mode`=1 → TEST.
    - Entering either state clears `bit_count`, `config_done` and `error`.
  - **PROG**
    - Each cycle in which the shift register holds a bit: drive that bit on `ccff_head`, assert `ccff_shift_en`, increment `bit_count`.
    - When the shift register empties, it reloads from the holding register in the same cycle if the holding register is full.
    - If the holding register is empty, the bit slot stalls: `ccff_shift_en`=0, `ccff_head` holds its value, `bit_count` is frozen.
    - The final word is partial when `BITSTREAM_SIZE % WORD_WIDTH` ≠ 0: only its upper remaining bits are shifted and the low bits are discarded.
    - When `bit_count` reaches `BITSTREAM_SIZE` → DONE.
    - Words offered after the last needed word are not accepted (`word_ready`=0 once the final word has been taken).
  - **TEST**
    - Cycle 0: `ccff_head`=1, `ccff_shift_en`=1.
    - Every later cycle: `ccff_head`=0, `ccff_shift_en`=1. `bit_count` counts cycles from 0.
    - `ccff_tail` is sampled each cycle. Pass when the first 1 is seen with `bit_count`==`BITSTREAM_SIZE`.
    - Fail when a 1 is seen earlier, or when `bit_count` reaches `BITSTREAM_SIZE+CHECK_MARGIN` with no 1 seen.
    - Pass sets `config_done`; fail sets `error`. Either outcome → DONE.
  - **DONE**
    - `ccff_head`=0, `ccff_shift_en`=0.
    - Returns to IDLE next cycle; sticky flags persist.
- `start` outside IDLE is ignored. The holding register is flushed on entry to IDLE.
- `prog_reset` asserted mid-operation forces all outputs to reset values immediately (async). No partial-state retention.

## Timing
- `start` sampled at edge E. Registered outputs reflect PROG/TEST from E.
- The first `ccff_shift_en`=1 occurs in the cycle after E if a word was already loadable (TEST: always).
- Handshake-to-head latency: a word accepted at edge A has its MSB on `ccff_head` no earlier than the cycle after A.
- With `word_valid` held high, PROG runs with no stalls. Total shift cycles = `BITSTREAM_SIZE`, and `config_done` rises one edge after the last shift.
- The simultaneous reload and handshake in the same cycle is legal: the holding register is both emptied and refilled.

## Test plan
- Reset: hold `prog_reset` for 3 cycles, release → all outputs 0, state IDLE; `start` during reset has no effect.
- Program, BITSTREAM_SIZE=10, WORD_WIDTH=4, words 0xA, 0x5, 0xC with `word_valid` always high:
  - `ccff_head` over the shift cycles = 1,0,1,0,0,1,0,1,1,1.
  - Exactly 10 `ccff_shift_en` cycles; `config_done`=1.
  - A 4th offered word is never accepted.
- Stall: same stream, `word_valid` low for 5 cycles after the first word → `ccff_shift_en`=0 and `bit_count` frozen at 4 during the gap; output sequence is unchanged.
- Self-test pass, BITSTREAM_SIZE=10, bench models a 10-flop chain gated by `ccff_shift_en` → `config_done`=1, `error`=0.
- Self-test fail:
  - 9-flop chain → `error`=1 (early).
  - Broken chain with tail tied 0 → `error`=1 once `bit_count`=14.
- Mid-operation reset: assert `prog_reset` at `bit_count`=5 → outputs 0 immediately. A fresh `start` then programs correctly from bit 0.

Source files
------------

// File: rtl/ccff_prog_ctrl.sv
// ccff_prog_ctrl: configuration-chain programming controller.
// Serializes bitstream words MSB-first onto the chain head. It can also run a
// chain-integrity self-test that launches one pulse and times its arrival at
// the chain tail.
// Ports:
//   prog_clk, prog_reset            clock, async active-high reset
//   start, mode                     operation request (mode 0 program, 1 self-test)
//   word_data/word_valid/word_ready bitstream word handshake from the loader
//   ccff_head, ccff_shift_en        registered serial bit and shift gate to the chain
//   ccff_tail                       chain tail input
//   busy, config_done, error        status (config_done/error are sticky)
//   bit_count                       bits shifted (program) or cycles elapsed (self-test)
module ccff_prog_ctrl #(
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned BITSTREAM_SIZE = 65656,
    parameter int unsigned CNT_WIDTH      = 24,
    parameter int unsigned CHECK_MARGIN   = 4
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  ccff_head,
    input  logic                  ccff_tail,
    output logic                  ccff_shift_en,
    output logic                  busy,
    output logic                  config_done,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  bit_count
);

    localparam int unsigned NUM_WORDS = (BITSTREAM_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int unsigned LAST_BITS = BITSTREAM_SIZE - (NUM_WORDS - 1) * WORD_WIDTH;
    localparam int unsigned SC_W      = $clog2(WORD_WIDTH + 1);

    localparam logic [CNT_WIDTH-1:0] BS_C = CNT_WIDTH'(BITSTREAM_SIZE);
    localparam logic [CNT_WIDTH-1:0] TO_C = CNT_WIDTH'(BITSTREAM_SIZE + CHECK_MARGIN);
    localparam logic [CNT_WIDTH-1:0] NW_C = CNT_WIDTH'(NUM_WORDS);

    typedef enum logic [1:0] {IDLE, PROG, TEST, DONE} state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  hold_last_q, hold_last_d;
    logic [WORD_WIDTH-1:0] sh_q, sh_d;
    logic [SC_W-1:0]       sh_cnt_q, sh_cnt_d;
    logic [CNT_WIDTH-1:0]  words_q, words_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  head_q, head_d;
    logic                  shift_en_q, shift_en_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        hold_last_d = hold_last_q;
        sh_d        = sh_q;
        sh_cnt_d    = sh_cnt_q;
        words_d     = words_q;
        cnt_d       = cnt_q;
        head_d      = head_q;
        shift_en_d  = 1'b0;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            IDLE: begin
                hold_full_d = 1'b0;
                sh_cnt_d    = '0;
                words_d     = '0;
                head_d      = 1'b0;
                if (start) begin
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    if (mode) begin
                        // Self-test launches the pulse in its first cycle.
                        state_d    = TEST;
                        head_d     = 1'b1;
                        shift_en_d = 1'b1;
                    end else begin
                        state_d = PROG;
                    end
                end
            end
            PROG: begin
                if (cnt_q == BS_C) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    head_d  = 1'b0;
                end else if (sh_cnt_q != '0) begin
                    head_d     = sh_q[WORD_WIDTH-1];
                    sh_d       = sh_q << 1;
                    sh_cnt_d   = sh_cnt_q - SC_W'(1);
                    shift_en_d = 1'b1;
                    cnt_d      = cnt_q + CNT_WIDTH'(1);
                end else if (hold_full_q) begin
                    // Reload and emit the MSB in the same slot; the final
                    // word only contributes its upper LAST_BITS bits.
                    head_d      = hold_q[WORD_WIDTH-1];
                    sh_d        = hold_q << 1;
                    sh_cnt_d    = (hold_last_q ? SC_W'(LAST_BITS) : SC_W'(WORD_WIDTH)) - SC_W'(1);
                    hold_full_d = 1'b0;
                    shift_en_d  = 1'b1;
                    cnt_d       = cnt_q + CNT_WIDTH'(1);
                end
                if (word_valid && ready_q) begin
                    hold_d      = word_data;
                    hold_full_d = 1'b1;
                    hold_last_d = (words_q == NW_C - CNT_WIDTH'(1));
                    words_d     = words_q + CNT_WIDTH'(1);
                end
            end
            TEST: begin
                head_d = 1'b0;
                if (ccff_tail) begin
                    state_d = DONE;
                    if (cnt_q == BS_C) done_d = 1'b1;
                    else               error_d = 1'b1;
                end else if (cnt_q == TO_C) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end else begin
                    shift_en_d = 1'b1;
                    cnt_d      = cnt_q + CNT_WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                head_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == PROG) && !hold_full_d && (words_d < NW_C);
    end

    // State and output registers.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            hold_last_q <= 1'b0;
            sh_q        <= '0;
            sh_cnt_q    <= '0;
            words_q     <= '0;
            cnt_q       <= '0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            hold_last_q <= hold_last_d;
            sh_q        <= sh_d;
            sh_cnt_q    <= sh_cnt_d;
            words_q     <= words_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign word_ready    = ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign config_done   = done_q;
    assign error         = error_q;
    assign bit_count     = cnt_q;

endmodule

// File: tb/tb_ccff_prog_ctrl.sv
// tb_ccff_prog_ctrl: directed bench for ccff_prog_ctrl with a 10-bit chain,
// 4-bit words and a small behavioural chain model on ccff_head/ccff_tail.
module tb_ccff_prog_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] word_data = '0;
    logic       word_valid = 1'b0;
    logic       word_ready;
    logic       head;
    logic       tail;
    logic       shift_en;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] bit_count;

    int total = 0;
    int bad   = 0;

    ccff_prog_ctrl #(
        .WORD_WIDTH    (4),
        .BITSTREAM_SIZE(10),
        .CNT_WIDTH     (8),
        .CHECK_MARGIN  (4)
    ) dut (
        .prog_clk     (clk),
        .prog_reset   (rst),
        .start        (start),
        .mode         (mode),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .ccff_head    (head),
        .ccff_tail    (tail),
        .ccff_shift_en(shift_en),
        .busy         (busy),
        .config_done  (done),
        .error        (error),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    // Chain model: 10 flops shifting when ccff_shift_en is high; tail tap selectable.
    logic [9:0] chain;
    int         tail_sel = 0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           chain <= '0;
        else if (shift_en) chain <= {chain[8:0], head};
    end
    assign tail = (tail_sel == 0) ? chain[9] : (tail_sel == 1) ? chain[8] : 1'b0;

    logic [3:0] words [4] = '{4'hA, 4'h5, 4'hC, 4'hF};
    logic [9:0] exp_seq = 10'b1010010111;
    logic [9:0] got;
    int nsh, nx, stall_seen, frozen_bad, idx, gap_left;
    logic xfer;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic m);
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Program run; gap = valid-low cycles after first word; stop_at != 0 resets mid-run.
    task automatic run_prog(input string name, input int gap, input int stop_at);
        nsh = 0; nx = 0; got = '0; stall_seen = 0; frozen_bad = 0; idx = 0; gap_left = 0;
        word_data  = words[0];
        word_valid = 1'b1;
        do_start(1'b0);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (stop_at != 0 && bit_count == 8'(stop_at)) begin
                rst = 1'b1;
                #1;
                check({name, "_reset_outs"},
                      {word_ready, head, shift_en, busy, done, error, bit_count}, '0);
                break;
            end
            if (!busy) break;
            if (shift_en) begin
                if (nsh < 10) got[9 - nsh] = head;
                nsh++;
                if (nsh == 5) check({name, "_done_low_mid"}, done, 1'b0);
            end
            if (bit_count != 8'(nsh)) frozen_bad++;
            if (!shift_en && nsh == 4) stall_seen++;
            xfer = word_valid & word_ready;
            if (xfer) nx++;
            @(posedge clk); #1;
            if (xfer && idx < 3) begin
                idx++;
                word_data = words[idx];
            end
            if (xfer && nx == 1 && gap > 0) begin
                word_valid = 1'b0;
                gap_left   = gap;
            end else if (gap_left > 0) begin
                gap_left--;
                if (gap_left == 0) word_valid = 1'b1;
            end
        end
        word_valid = 1'b0;
        if (stop_at != 0) begin
            @(posedge clk); #1 rst = 1'b0;
        end else begin
            check({name, "_finished"}, busy, 1'b0);
            check({name, "_seq"}, got, exp_seq);
            check({name, "_shift_cnt"}, nsh, 10);
            check({name, "_xfers"}, nx, 3);
            check({name, "_count_track"}, frozen_bad, 0);
            check({name, "_stall_at4"}, (stall_seen > 0), (gap > 0));
            check({name, "_done"}, done, 1'b1);
            check({name, "_error"}, error, 1'b0);
        end
    endtask

    task automatic run_test(input string name, input int sel, input logic exp_done,
                            input logic exp_err, input int exp_cnt);
        pulse_reset();
        tail_sel = sel;
        do_start(1'b1);
        @(negedge clk);
        check({name, "_cyc0"}, {head, shift_en, bit_count}, {2'b11, 8'd0});
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({name, "_finished"}, busy, 1'b0);
        check({name, "_done"}, done, exp_done);
        check({name, "_error"}, error, exp_err);
        check({name, "_bit_count"}, bit_count, 8'(exp_cnt));
    endtask

    initial begin
        // Reset held for 3 cycles with start asserted.
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("in_reset_outs", {word_ready, head, shift_en, busy, done, error, bit_count}, '0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_reset_outs", {word_ready, head, shift_en, busy, done, error, bit_count}, '0);

        run_prog("prog", 0, 0);
        run_prog("stall", 5, 0);

        run_test("test_pass", 0, 1'b1, 1'b0, 10);
        run_test("test_short", 1, 1'b0, 1'b1, 9);
        run_test("test_broken", 2, 1'b0, 1'b1, 14);

        run_prog("midrst", 0, 5);
        run_prog("fresh", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
